pipe_stage_skid: RTL

//  Parametrised successor of the fixed-field decode->execute register: one generic pipeline stage

---
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_skid #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          CLEAR_ON_KILL = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             acc, pop;

  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_stage_skid: WIDTH must be >= 1");
  end

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign out_data  = main_data_q;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_KILL) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = ONE;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_data_d = in_data;
          end else if (acc) begin
            state_d     = FULL;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            if (CLEAR_ON_KILL) main_data_d = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            if (CLEAR_ON_KILL) skid_data_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, so out_data reads 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_hit, flush_hit;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be >= 1");
  end

  assign stall_hit = out_valid & ~out_ready;
  assign flush_hit = flush & (state_q != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_hit && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  // Counters are absent; the width parameter is still range-checked for portable configs.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be >= 1");
  end
`endif

endmodule
